// File: rtl/imm_pkg.sv
// Shared definitions for the pipelined LEGv8 immediate extender: format
// encodings, instruction field positions and the sign-extension helper.
package imm_pkg;

  localparam int IMM_W      = 26;
  localparam int MOV_LANE_W = 16;

  typedef enum logic [2:0] {
    IMM_I    = 3'b000,
    IMM_D    = 3'b001,
    IMM_B    = 3'b010,
    IMM_CB   = 3'b011,
    IMM_MOVZ = 3'b100,
    IMM_MOVN = 3'b101,
    IMM_MOVK = 3'b110,
    IMM_ILL  = 3'b111
  } imm_ctrl_e;

  localparam int I_MSB   = 21;
  localparam int I_LSB   = 10;
  localparam int D_MSB   = 20;
  localparam int D_LSB   = 12;
  localparam int B_MSB   = 25;
  localparam int B_LSB   = 0;
  localparam int CB_MSB  = 23;
  localparam int CB_LSB  = 5;
  localparam int MOV_MSB = 20;
  localparam int MOV_LSB = 5;
  localparam int HW_MSB  = 22;
  localparam int HW_LSB  = 21;

  // Park the field's MSB at bit 63, then arithmetic-shift it back down so the
  // sign fills everything above it.
  function automatic logic [63:0] sextField(input logic [IMM_W-1:0] imm,
                                            input int msb, input int lsb);
    logic signed [63:0] t;
    t = $signed({imm, 38'b0});
    t = t <<< (IMM_W - 1 - msb);
    t = t >>> (63 - msb + lsb);
    return t;
  endfunction

endpackage

// File: rtl/imm_extend_core.sv
// Combinational format decode, sign/zero extension, MOV lane shift and mask.
// Optional macro IMM_BR_SCALE_EN turns B/CB word offsets into byte offsets.
module imm_extend_core
  import imm_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [IMM_W-1:0]  imm_i,
  input  logic [2:0]        ctrl_i,
  output logic [DATA_W-1:0] imm_o,
  output logic [DATA_W-1:0] mask_o,
  output logic              err_o
);

`ifdef IMM_BR_SCALE_EN
  localparam int BR_SHIFT = 2;
`else
  localparam int BR_SHIFT = 0;
`endif

  logic [1:0]        hw;
  logic [5:0]        laneShift;
  logic [DATA_W-1:0] movShift;
  logic [DATA_W-1:0] laneMask;
  logic              movFmt;
  logic              hwIllegal;

  // A 32-bit datapath has only two 16-bit lanes, so hw values 2 and 3 are illegal there.
  always_comb begin
    hw        = imm_i[HW_MSB:HW_LSB];
    laneShift = {hw, 4'b0000};
    movShift  = DATA_W'(64'(imm_i[MOV_MSB:MOV_LSB]) << laneShift);
    laneMask  = DATA_W'(64'({MOV_LANE_W{1'b1}}) << laneShift);
    movFmt    = ctrl_i[2] && (ctrl_i != IMM_ILL);
    hwIllegal = (DATA_W == 32) && hw[1];

    imm_o  = '0;
    mask_o = '0;
    err_o  = 1'b0;
    case (imm_ctrl_e'(ctrl_i))
      IMM_I:    imm_o = DATA_W'(sextField(imm_i, I_MSB, I_LSB));
      IMM_D:    imm_o = DATA_W'(sextField(imm_i, D_MSB, D_LSB));
      IMM_B:    imm_o = DATA_W'(sextField(imm_i, B_MSB, B_LSB) << BR_SHIFT);
      IMM_CB:   imm_o = DATA_W'(sextField(imm_i, CB_MSB, CB_LSB) << BR_SHIFT);
      IMM_MOVZ: imm_o = movShift;
      IMM_MOVN: imm_o = ~movShift;
      IMM_MOVK: begin
        imm_o  = movShift;
        mask_o = laneMask;
      end
      default:  err_o = 1'b1;
    endcase

    if (movFmt && hwIllegal) begin
      imm_o  = '0;
      mask_o = '0;
      err_o  = 1'b1;
    end
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Two-stage elastic immediate extender: S1 holds the raw request, S2 the
// extended result that drives the outputs. Optional macro: IMM_BR_SCALE_EN.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 5
) (
  input  logic              CLK,
  input  logic              Reset_L,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [2:0]        in_ctrl,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_mask,
  output logic [2:0]        out_ctrl,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err
);

  logic              rdy_q;
  logic              s1Valid_q, s1Valid_d;
  logic [IMM_W-1:0]  s1Imm_q;
  logic [2:0]        s1Ctrl_q;
  logic [TAG_W-1:0]  s1Tag_q;
  logic              s2Valid_q, s2Valid_d;
  logic [DATA_W-1:0] s2Imm_q;
  logic [DATA_W-1:0] s2Mask_q;
  logic [2:0]        s2Ctrl_q;
  logic [TAG_W-1:0]  s2Tag_q;
  logic              s2Err_q;

  logic              s2Adv;
  logic              s1Adv;
  logic              accept;
  logic              s2Load;
  logic [DATA_W-1:0] extImm;
  logic [DATA_W-1:0] extMask;
  logic              extErr;

  imm_extend_core #(.DATA_W(DATA_W)) u_core (
    .imm_i  (s1Imm_q),
    .ctrl_i (s1Ctrl_q),
    .imm_o  (extImm),
    .mask_o (extMask),
    .err_o  (extErr)
  );

  // in_ready depends only on state and flush, never on in_valid.
  always_comb begin
    s2Adv     = !s2Valid_q || out_ready;
    s1Adv     = !s1Valid_q || s2Adv;
    in_ready  = rdy_q && s1Adv && !flush;
    accept    = in_valid && in_ready;
    s2Load    = s2Adv && s1Valid_q && !flush;
    s1Valid_d = flush ? 1'b0 : (s1Adv ? accept    : s1Valid_q);
    s2Valid_d = flush ? 1'b0 : (s2Adv ? s1Valid_q : s2Valid_q);
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      rdy_q     <= 1'b0;
      s1Valid_q <= 1'b0;
      s1Imm_q   <= '0;
      s1Ctrl_q  <= '0;
      s1Tag_q   <= '0;
      s2Valid_q <= 1'b0;
      s2Imm_q   <= '0;
      s2Mask_q  <= '0;
      s2Ctrl_q  <= '0;
      s2Tag_q   <= '0;
      s2Err_q   <= 1'b0;
    end else begin
      rdy_q     <= 1'b1;
      s1Valid_q <= s1Valid_d;
      s2Valid_q <= s2Valid_d;
      if (accept) begin
        s1Imm_q  <= in_imm;
        s1Ctrl_q <= in_ctrl;
        s1Tag_q  <= in_tag;
      end
      if (s2Load) begin
        s2Imm_q  <= extImm;
        s2Mask_q <= extMask;
        s2Ctrl_q <= s1Ctrl_q;
        s2Tag_q  <= s1Tag_q;
        s2Err_q  <= extErr;
      end
    end
  end

  assign out_valid = s2Valid_q;
  assign out_imm   = s2Imm_q;
  assign out_mask  = s2Mask_q;
  assign out_ctrl  = s2Ctrl_q;
  assign out_tag   = s2Tag_q;
  assign out_err   = s2Err_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: a 64-bit and a 32-bit instance share
// one stimulus stream; B/CB expectations follow IMM_BR_SCALE_EN.
module tb_imm_extend_pipe;
  import imm_pkg::*;

`ifdef IMM_BR_SCALE_EN
  localparam int BRS = 2;
`else
  localparam int BRS = 0;
`endif

  logic        CLK = 1'b0;
  logic        Reset_L, flush, in_valid, out_ready;
  logic [25:0] in_imm;
  logic [2:0]  in_ctrl;
  logic [4:0]  in_tag;

  logic        rdy64, val64, err64;
  logic [63:0] imm64, mask64;
  logic [2:0]  ctrl64;
  logic [4:0]  tag64;
  logic        rdy32, val32, err32;
  logic [31:0] imm32, mask32;
  logic [2:0]  ctrl32;
  logic [4:0]  tag32;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 CLK = ~CLK;

  imm_extend_pipe #(.DATA_W(64), .TAG_W(5)) dut64 (
    .CLK(CLK), .Reset_L(Reset_L), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64), .in_imm(in_imm), .in_ctrl(in_ctrl), .in_tag(in_tag),
    .out_valid(val64), .out_ready(out_ready), .out_imm(imm64), .out_mask(mask64),
    .out_ctrl(ctrl64), .out_tag(tag64), .out_err(err64)
  );

  imm_extend_pipe #(.DATA_W(32), .TAG_W(5)) dut32 (
    .CLK(CLK), .Reset_L(Reset_L), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy32), .in_imm(in_imm), .in_ctrl(in_ctrl), .in_tag(in_tag),
    .out_valid(val32), .out_ready(out_ready), .out_imm(imm32), .out_mask(mask32),
    .out_ctrl(ctrl32), .out_tag(tag32), .out_err(err32)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] c, input logic [25:0] imm,
                               input logic [4:0] t, input logic v);
    in_ctrl  = c;
    in_imm   = imm;
    in_tag   = t;
    in_valid = v;
  endtask

  function automatic logic [25:0] movImm(input logic [15:0] v, input logic [1:0] hw);
    return {3'b000, hw, v, 5'b00000};
  endfunction

  // One isolated request with out_ready=1; result expected two edges after acceptance.
  task automatic oneShot(input string name, input logic [2:0] c, input logic [25:0] imm,
                         input logic [4:0] t, input logic [63:0] e64, input logic [63:0] m64,
                         input logic eErr64, input logic [31:0] e32, input logic [31:0] m32,
                         input logic eErr32);
    applyStimulus(c, imm, t, 1'b1);
    @(negedge CLK);
    checkOutput({name, "_ready"}, 64'(rdy64), 64'd1);
    @(posedge CLK); #1;
    applyStimulus(3'b000, 26'd0, 5'd0, 1'b0);
    @(negedge CLK);
    checkOutput({name, "_early"}, 64'(val64), 64'd0);
    @(posedge CLK);
    @(negedge CLK);
    checkOutput({name, "_valid"}, 64'(val64), 64'd1);
    checkOutput({name, "_imm64"}, imm64, e64);
    checkOutput({name, "_mask64"}, mask64, m64);
    checkOutput({name, "_err64"}, 64'(err64), 64'(eErr64));
    checkOutput({name, "_tag"}, 64'(tag64), 64'(t));
    checkOutput({name, "_ctrl"}, 64'(ctrl64), 64'(c));
    checkOutput({name, "_imm32"}, 64'(imm32), 64'(e32));
    checkOutput({name, "_mask32"}, 64'(mask32), 64'(m32));
    checkOutput({name, "_err32"}, 64'(err32), 64'(eErr32));
    @(posedge CLK); #1;
  endtask

  logic [2:0]  sCtrl [4];
  logic [25:0] sImm  [4];
  logic [63:0] sExp64[4];
  logic [31:0] sExp32[4];
  logic [2:0]  bCtrl [3];
  logic [25:0] bImm  [3];
  logic [4:0]  bTag  [3];
  logic [63:0] bExp  [3];
  logic [4:0]  gotTag[4];
  logic [63:0] gotImm[4];

  initial begin
    int idx;
    int got;
    logic acc, unstable, haveRef, lastReady;
    logic [63:0] refImm;
    logic [4:0]  refTag;

    Reset_L = 1'b0; flush = 1'b0; out_ready = 1'b1;
    applyStimulus(3'b000, 26'd0, 5'd0, 1'b0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checkOutput("rst_valid", 64'(val64), 64'd0);
    checkOutput("rst_imm", imm64, 64'd0);
    checkOutput("rst_mask", mask64, 64'd0);
    checkOutput("rst_err", 64'(err64), 64'd0);
    checkOutput("rst_tag", 64'(tag64), 64'd0);
    checkOutput("rst_ctrl", 64'(ctrl64), 64'd0);
    checkOutput("rst_valid32", 64'(val32), 64'd0);
    @(posedge CLK); #1;
    Reset_L = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("rst_ready", 64'(rdy64), 64'd1);
    @(posedge CLK); #1;

    // Back-to-back stream: I, D, B, CB.
    sCtrl[0] = 3'b000; sImm[0] = {4'b0, 12'h800, 10'b0};
    sCtrl[1] = 3'b001; sImm[1] = {5'b0, 9'h1FF, 12'b0};
    sCtrl[2] = 3'b010; sImm[2] = 26'h3FFFFFF;
    sCtrl[3] = 3'b011; sImm[3] = {2'b0, 19'h00005, 5'b0};
    sExp64[0] = 64'hFFFFFFFFFFFFF800;       sExp32[0] = 32'hFFFFF800;
    sExp64[1] = 64'hFFFFFFFFFFFFFFFF;       sExp32[1] = 32'hFFFFFFFF;
    sExp64[2] = 64'hFFFFFFFFFFFFFFFF << BRS; sExp32[2] = 32'hFFFFFFFF << BRS;
    sExp64[3] = 64'h5 << BRS;                sExp32[3] = 32'h5 << BRS;
    for (int c = 0; c < 6; c++) begin
      if (c < 4) applyStimulus(sCtrl[c], sImm[c], 5'(c), 1'b1);
      else       applyStimulus(3'b000, 26'd0, 5'd0, 1'b0);
      @(negedge CLK);
      if (c < 4) checkOutput($sformatf("stream_ready%0d", c), 64'(rdy64), 64'd1);
      if (c == 1) checkOutput("stream_latency", 64'(val64), 64'd0);
      if (c >= 2) begin
        checkOutput($sformatf("stream_valid%0d", c - 2), 64'(val64), 64'd1);
        checkOutput($sformatf("stream_imm%0d", c - 2), imm64, sExp64[c - 2]);
        checkOutput($sformatf("stream_tag%0d", c - 2), 64'(tag64), 64'(c - 2));
        checkOutput($sformatf("stream_imm32_%0d", c - 2), 64'(imm32), 64'(sExp32[c - 2]));
        checkOutput($sformatf("stream_mask%0d", c - 2), mask64, 64'd0);
      end
      @(posedge CLK); #1;
    end

    oneShot("movk_hw2", 3'b110, movImm(16'hBEEF, 2'd2), 5'd1,
            64'h0000BEEF00000000, 64'h0000FFFF00000000, 1'b0, 32'h0, 32'h0, 1'b1);
    oneShot("movn_hw0", 3'b101, movImm(16'h0001, 2'd0), 5'd2,
            64'hFFFFFFFFFFFFFFFE, 64'h0, 1'b0, 32'hFFFFFFFE, 32'h0, 1'b0);
    oneShot("movz_hw3", 3'b100, movImm(16'h1234, 2'd3), 5'd3,
            64'h1234000000000000, 64'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    oneShot("movz_hw1", 3'b100, movImm(16'hABCD, 2'd1), 5'd4,
            64'h00000000ABCD0000, 64'h0, 1'b0, 32'hABCD0000, 32'h0, 1'b0);
    oneShot("movk_hw1", 3'b110, movImm(16'h00FF, 2'd1), 5'd5,
            64'h0000000000FF0000, 64'h00000000FFFF0000, 1'b0, 32'h00FF0000, 32'hFFFF0000, 1'b0);
    oneShot("illegal", 3'b111, 26'h2ABCDEF, 5'd6, 64'h0, 64'h0, 1'b1, 32'h0, 32'h0, 1'b1);
    oneShot("i_pos", 3'b000, {4'b0, 12'h7FF, 10'b0}, 5'd7,
            64'h7FF, 64'h0, 1'b0, 32'h7FF, 32'h0, 1'b0);
    oneShot("b_one", 3'b010, 26'h0000001, 5'd8,
            64'h1 << BRS, 64'h0, 1'b0, 32'h1 << BRS, 32'h0, 1'b0);

    // Backpressure: out_ready low for five cycles while three requests are offered.
    bCtrl[0] = 3'b100; bImm[0] = movImm(16'h1111, 2'd0); bTag[0] = 5'd10; bExp[0] = 64'h1111;
    bCtrl[1] = 3'b100; bImm[1] = movImm(16'h2222, 2'd1); bTag[1] = 5'd11; bExp[1] = 64'h22220000;
    bCtrl[2] = 3'b001; bImm[2] = {5'b0, 9'h005, 12'b0};  bTag[2] = 5'd12; bExp[2] = 64'h5;
    out_ready = 1'b0; idx = 0; unstable = 1'b0; haveRef = 1'b0; lastReady = 1'b1;
    refImm = '0; refTag = '0;
    for (int c = 0; c < 5; c++) begin
      if (idx < 3) applyStimulus(bCtrl[idx], bImm[idx], bTag[idx], 1'b1);
      else         applyStimulus(3'b000, 26'd0, 5'd0, 1'b0);
      @(negedge CLK);
      acc = in_valid && rdy64;
      lastReady = rdy64;
      if (val64) begin
        if (!haveRef) begin
          refImm = imm64; refTag = tag64; haveRef = 1'b1;
        end else if (imm64 !== refImm || tag64 !== refTag) begin
          unstable = 1'b1;
        end
      end
      @(posedge CLK);
      if (acc) idx++;
      #1;
    end
    checkOutput("bp_accepted", 64'(idx), 64'd2);
    checkOutput("bp_ready_low", 64'(lastReady), 64'd0);
    checkOutput("bp_stable", 64'(unstable), 64'd0);
    checkOutput("bp_head_tag", 64'(refTag), 64'(bTag[0]));
    checkOutput("bp_head_imm", refImm, bExp[0]);

    out_ready = 1'b1; got = 0;
    for (int c = 0; c < 8; c++) begin
      if (idx < 3) applyStimulus(bCtrl[idx], bImm[idx], bTag[idx], 1'b1);
      else         applyStimulus(3'b000, 26'd0, 5'd0, 1'b0);
      @(negedge CLK);
      acc = in_valid && rdy64;
      if (val64) begin
        if (got < 4) begin
          gotTag[got] = tag64; gotImm[got] = imm64;
        end
        got++;
      end
      @(posedge CLK);
      if (acc) idx++;
      #1;
    end
    checkOutput("bp_all_accepted", 64'(idx), 64'd3);
    checkOutput("bp_count", 64'(got), 64'd3);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("bp_tag%0d", i), 64'(gotTag[i]), 64'(bTag[i]));
      checkOutput($sformatf("bp_imm%0d", i), gotImm[i], bExp[i]);
    end

    // Flush with both stages full and a request on offer.
    out_ready = 1'b0;
    applyStimulus(3'b100, movImm(16'h0AAA, 2'd0), 5'd20, 1'b1);
    @(posedge CLK); #1;
    applyStimulus(3'b100, movImm(16'h0BBB, 2'd0), 5'd21, 1'b1);
    @(posedge CLK); #1;
    applyStimulus(3'b100, movImm(16'h0CCC, 2'd0), 5'd22, 1'b1);
    flush = 1'b1;
    @(negedge CLK);
    checkOutput("fl_full", 64'(val64), 64'd1);
    checkOutput("fl_ready", 64'(rdy64), 64'd0);
    @(posedge CLK); #1;
    flush = 1'b0; out_ready = 1'b1;
    applyStimulus(3'b100, movImm(16'h00FF, 2'd0), 5'd23, 1'b1);
    @(negedge CLK);
    checkOutput("fl_cleared", 64'(val64), 64'd0);
    checkOutput("fl_ready_after", 64'(rdy64), 64'd1);
    @(posedge CLK); #1;
    applyStimulus(3'b000, 26'd0, 5'd0, 1'b0);
    @(negedge CLK);
    checkOutput("fl_no_ghost", 64'(val64), 64'd0);
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("fl_next_valid", 64'(val64), 64'd1);
    checkOutput("fl_next_tag", 64'(tag64), 64'd23);
    checkOutput("fl_next_imm", imm64, 64'hFF);
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("fl_drained", 64'(val64), 64'd0);
    @(posedge CLK); #1;

    // Asynchronous reset while a MOVK result is stalled at the output.
    out_ready = 1'b0;
    applyStimulus(3'b110, movImm(16'hBEEF, 2'd1), 5'd7, 1'b1);
    @(posedge CLK); #1;
    applyStimulus(3'b000, 26'd0, 5'd0, 1'b0);
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("ar_stalled", 64'(val64), 64'd1);
    checkOutput("ar_stalled_mask", mask64, 64'h00000000FFFF0000);
    #2 Reset_L = 1'b0;
    #1;
    checkOutput("ar_valid", 64'(val64), 64'd0);
    checkOutput("ar_imm", imm64, 64'd0);
    checkOutput("ar_mask", mask64, 64'd0);
    checkOutput("ar_tag", 64'(tag64), 64'd0);
    checkOutput("ar_ctrl", 64'(ctrl64), 64'd0);
    checkOutput("ar_err32", 64'(err32), 64'd0);
    @(posedge CLK); #1;
    Reset_L = 1'b1; out_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("ar_ready", 64'(rdy64), 64'd1);
    checkOutput("ar_idle", 64'(val64), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, elastic successor to the combinational immediate sign-extender in the LEGv8 datapath.
- Accepts a 26-bit instruction immediate field plus format control through a valid/ready handshake.
- Produces the extended/shifted DATA_W immediate, a MOVK merge mask and an error flag through a two-stage registered pipeline.
- Sits between decode and register-read/execute, and supports stall (backpressure) and flush.

Parameters:
- DATA_W, 64, output immediate width; legal values are 32 or 64 only.
- TAG_W, 5, width of the opaque tag carried alongside each request (e.g. destination register).
- IMM_W, 26, input immediate field width; fixed, not to be overridden.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- Reset_L  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous kill of all in-flight entries.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request this cycle.
- in_imm  input  26  instruction bits [25:0].
- in_ctrl  input  3  format select.
- in_tag  input  TAG_W  passthrough tag.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_imm  output  DATA_W  extended immediate.
- out_mask  output  DATA_W  field mask; non-zero only for MOVK.
- out_ctrl  output  3  ctrl of the result.
- out_tag  output  TAG_W  tag of the result.
- out_err  output  1  illegal ctrl or illegal hw shift.

Behaviour:
- Reset (Reset_L=0, asynchronous): both stage valids clear. out_valid, out_imm, out_mask, out_ctrl, out_tag and out_err all 0. in_ready is 1 one cycle after reset deasserts.
- Stage 1 (S1) registers the raw imm/ctrl/tag and decodes the field and hw = in_imm[22:21]. Stage 2 (S2) registers the extended result, which drives the outputs directly (no combinational path from input to output).
- Latency: 2 cycles from an accepted request to out_valid. Throughput: 1 per cycle with no stall.
- Handshake:
  - Transfer happens when valid && ready.
  - S2 advances when !s2_valid || out_ready.
  - S1 advances when it is empty or S2 advances. in_ready = (!s1_valid || s2_adv) && !flush.
  - While out_valid && !out_ready, all outputs stay stable.
  - in_ready must not depend combinationally on in_valid.
- Formats (sx = sign-extend to DATA_W):
  - 000 I: sx(in_imm[21:10]); sign bit is in_imm[21].
  - 001 D: sx(in_imm[20:12]).
  - 010 B: sx(in_imm[25:0]).
  - 011 CB: sx(in_imm[23:5]).
  - 100 MOVZ: zero-extended in_imm[20:5] << 16*hw.
  - 101 MOVN: bitwise NOT of (in_imm[20:5] << 16*hw).
  - 110 MOVK: out_imm = in_imm[20:5] << 16*hw; out_mask = 16'hFFFF << 16*hw.
  - 111: illegal; out_imm=0, out_err=1.
- out_mask is 0 for every ctrl except MOVK.
- Illegal hw: for DATA_W=32 with a MOV* format and hw >= 2, out_imm=0, out_mask=0, out_err=1. For DATA_W=64, every hw value is legal.
- For DATA_W=32, B/CB/I/D results are the sign-extension truncated to 32 bits.
- Flush: on a flush edge, both stage valids clear; a request offered in the same cycle is not accepted (in_ready=0). Data registers may retain stale values, but out_valid=0.
- Reset mid-transfer: an asynchronous assert drops everything, including an output that is stalled but not yet taken.

Optional Feature:
- Macro: IMM_BR_SCALE_EN.
- Defined: B and CB results are additionally shifted left by 2 (byte offset; bits shifted out of DATA_W are discarded).
- Undefined: B/CB results are the word offset, as listed above.
- All other formats are unaffected either way.

Decomposition:
- Shared package/header imm_pkg:
  - Ctrl encodings IMM_I, IMM_D, IMM_B, IMM_CB, IMM_MOVZ, IMM_MOVN, IMM_MOVK, IMM_ILL.
  - Field bit-position constants.
  - The MOV lane width constant 16.
- One natural sub-module: imm_extend_core, the purely combinational format/extend/shift/mask function used between S1 and S2. The pipeline/handshake stays in the top module.

Test Plan:
- DATA_W=64, out_ready=1; stream I imm12=0x800, D imm9=0x1FF, B imm26=0x3FFFFFF, CB imm19=0x00005 -> outputs 0xFFFFFFFFFFFFF800, 0xFFFFFFFFFFFFFFFF, 0xFFFFFFFFFFFFFFFF, 0x5. Each arrives 2 cycles after acceptance, one per cycle, tags in order.
- MOVK imm16=0xBEEF hw=2 -> out_imm 0x0000BEEF00000000, out_mask 0x0000FFFF00000000. MOVN imm16=0x0001 hw=0 -> 0xFFFFFFFFFFFFFFFE.
- Backpressure: hold out_ready=0 for 5 cycles with 3 requests offered -> exactly 2 accepted (in_ready drops); outputs stable throughout. Release -> results in order with no loss or duplication.
- Flush with both stages full and in_valid=1 -> next cycle out_valid=0; the offered request is not accepted; the next request emerges after 2 cycles.
- DATA_W=32: MOVZ hw=3 -> out_err=1, out_imm=0. ctrl=111 -> out_err=1.
- Assert Reset_L=0 asynchronously mid-stall -> all outputs 0 immediately. With IMM_BR_SCALE_EN defined, B imm26=0x0000001 -> 0x4.
